// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-ported register file with power-on clearing sweep and registered bypassed reads
// Optional feature: REGFILE_X0_ZERO_EN hardwires entry 0 to zero.
module regfile_mp #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rd_valid,
  output logic            rd_retry,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic            we,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] dest,
  input  logic            dest_long,
  input  logic            ack_valid,
  input  logic [AW-1:0]   ack_rd,
  input  logic [XLEN-1:0] ack_data,
  output logic            dout_valid,
  input  logic            dout_retry,
  output logic [XLEN-1:0] data1,
  output logic [XLEN-1:0] data2,
  output logic            init_done
);

  typedef enum logic {CLEAR, READY} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mem [NREG];
  logic            dout_valid_q, dout_valid_d;
  logic [XLEN-1:0] data1_q, data1_d;
  logic [XLEN-1:0] data2_q, data2_d;
  logic            ready, accept, wr_we, wr_ack;

  assign ready = (state_q == READY);

`ifdef REGFILE_X0_ZERO_EN
  assign wr_we  = ready && we && (rd != '0);
  assign wr_ack = ready && ack_valid && (ack_rd != '0);
`else
  assign wr_we  = ready && we;
  assign wr_ack = ready && ack_valid;
`endif

  assign rd_retry   = !ready || (dout_valid_q && dout_retry);
  assign accept     = rd_valid && !rd_retry;
  assign dout_valid = dout_valid_q;
  assign data1      = data1_q;
  assign data2      = data2_q;
  assign init_done  = ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == AW'(NREG - 1)) state_d = READY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Ack write is issued after the execute write so it wins on an index collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == CLEAR) begin
        mem[cnt_q] <= '0;
      end else begin
        if (wr_we) begin
          if (dest_long) mem[rd] <= dest;
          else           mem[rd][31:0] <= dest[31:0];
        end
        if (wr_ack) mem[ack_rd] <= ack_data;
      end
    end
  end

  function automatic logic [XLEN-1:0] fwd(input logic [AW-1:0] idx, input logic [XLEN-1:0] stored,
                                          input logic we_hit, input logic ack_hit);
    logic [XLEN-1:0] v;
    v = stored;
    if (we_hit) v = dest_long ? dest : {stored[XLEN-1:32], dest[31:0]};
    if (ack_hit) v = ack_data;
`ifdef REGFILE_X0_ZERO_EN
    if (idx == '0) v = '0;
`else
    if (idx == '0) v = v;
`endif
    return v;
  endfunction

  always_comb begin
    dout_valid_d = dout_valid_q;
    data1_d      = data1_q;
    data2_d      = data2_q;
    if (accept) begin
      dout_valid_d = 1'b1;
      data1_d = fwd(rs1, mem[rs1], wr_we && (rd == rs1), wr_ack && (ack_rd == rs1));
      data2_d = fwd(rs2, mem[rs2], wr_we && (rd == rs2), wr_ack && (ack_rd == rs2));
    end else if (dout_valid_q && !dout_retry) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_valid_q <= 1'b0;
      data1_q      <= '0;
      data2_q      <= '0;
    end else begin
      dout_valid_q <= dout_valid_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;

  localparam int XLEN = 64;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            rd_valid = 1'b0;
  logic            rd_retry;
  logic [AW-1:0]   rs1 = '0, rs2 = '0;
  logic            we = 1'b0;
  logic [AW-1:0]   rd = '0;
  logic [XLEN-1:0] dest = '0;
  logic            dest_long = 1'b0;
  logic            ack_valid = 1'b0;
  logic [AW-1:0]   ack_rd = '0;
  logic [XLEN-1:0] ack_data = '0;
  logic            dout_valid;
  logic            dout_retry = 1'b0;
  logic [XLEN-1:0] data1, data2;
  logic            init_done;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_mp #(.XLEN(XLEN), .NREG(32), .AW(AW)) dut (
    .clk(clk), .reset(reset), .rd_valid(rd_valid), .rd_retry(rd_retry),
    .rs1(rs1), .rs2(rs2), .we(we), .rd(rd), .dest(dest), .dest_long(dest_long),
    .ack_valid(ack_valid), .ack_rd(ack_rd), .ack_data(ack_data),
    .dout_valid(dout_valid), .dout_retry(dout_retry),
    .data1(data1), .data2(data2), .init_done(init_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic wait_init(output int n);
    n = 0;
    while (init_done !== 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic do_write(input logic [AW-1:0] idx, input logic [XLEN-1:0] val, input logic lng);
    we = 1'b1; rd = idx; dest = val; dest_long = lng;
    tick();
    we = 1'b0;
  endtask

  task automatic issue_read(input logic [AW-1:0] a, input logic [AW-1:0] b);
    rd_valid = 1'b1; rs1 = a; rs2 = b;
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic pulse_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1;
    tick(); tick();
    n_checks++; if (dout_valid !== 1'b0) begin $display("FAIL reset_dout_valid got %0b exp 0", dout_valid); n_fail++; end
    n_checks++; if (data1 !== 64'h0) begin $display("FAIL reset_data1 got %h exp 0", data1); n_fail++; end
    n_checks++; if (data2 !== 64'h0) begin $display("FAIL reset_data2 got %h exp 0", data2); n_fail++; end
    n_checks++; if (init_done !== 1'b0) begin $display("FAIL reset_init_done got %0b exp 0", init_done); n_fail++; end
    n_checks++; if (rd_retry !== 1'b1) begin $display("FAIL reset_rd_retry got %0b exp 1", rd_retry); n_fail++; end
    reset = 1'b0;
    wait_init(n);
    n_checks++; if (n != 32) begin $display("FAIL first_sweep_len got %0d exp 32", n); n_fail++; end
  endtask

  task automatic test_sweep;
    int n;
    do_write(5'd2, 64'h2222, 1'b1);
    do_write(5'd5, 64'h5555_0000_0000_0005, 1'b1);
    do_write(5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    issue_read(5'd5, 5'd31);
    n_checks++; if (data1 !== 64'h5555_0000_0000_0005 || data2 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      $display("FAIL preload_read got %h/%h exp 5555000000000005/ffffffffffffffff", data1, data2); n_fail++; end
    pulse_reset();
    repeat (20) tick();
    n_checks++; if (rd_retry !== 1'b1 || init_done !== 1'b0) begin
      $display("FAIL clear_handshake got retry=%0b init=%0b exp 1/0", rd_retry, init_done); n_fail++; end
    do_write(5'd2, 64'h55, 1'b1);
    wait_init(n);
    n_checks++; if (n + 21 != 32) begin $display("FAIL sweep_len got %0d exp 32", n + 21); n_fail++; end
    issue_read(5'd5, 5'd31);
    n_checks++; if (data1 !== 64'h0 || data2 !== 64'h0) begin
      $display("FAIL sweep_cleared got %h/%h exp 0/0", data1, data2); n_fail++; end
    issue_read(5'd2, 5'd2);
    n_checks++; if (data1 !== 64'h0) begin $display("FAIL clear_ignores_we got %h exp 0", data1); n_fail++; end
  endtask

  task automatic test_partial_write;
    do_write(5'd3, 64'hAAAA_AAAA_5555_5555, 1'b1);
    do_write(5'd3, 64'hFFFF_FFFF_1234_5678, 1'b0);
    issue_read(5'd3, 5'd3);
    n_checks++; if (data1 !== 64'hAAAA_AAAA_1234_5678 || data2 !== 64'hAAAA_AAAA_1234_5678) begin
      $display("FAIL partial_write got %h/%h exp aaaaaaaa12345678", data1, data2); n_fail++; end
  endtask

  task automatic test_collision_bypass;
    we = 1'b1; rd = 5'd7; dest = 64'h11; dest_long = 1'b1;
    ack_valid = 1'b1; ack_rd = 5'd7; ack_data = 64'h22;
    issue_read(5'd7, 5'd7);
    we = 1'b0; ack_valid = 1'b0;
    n_checks++; if (data1 !== 64'h22 || data2 !== 64'h22 || dout_valid !== 1'b1) begin
      $display("FAIL collision_bypass got %h/%h v=%0b exp 22/22 v=1", data1, data2, dout_valid); n_fail++; end
    tick();
    issue_read(5'd7, 5'd0);
    n_checks++; if (data1 !== 64'h22) begin $display("FAIL collision_stored got %h exp 22", data1); n_fail++; end
    do_write(5'd9, 64'hFFFF_FFFF_0000_0000, 1'b1);
    we = 1'b1; rd = 5'd9; dest = 64'h7777_7777_0000_ABCD; dest_long = 1'b0;
    issue_read(5'd1, 5'd9);
    we = 1'b0;
    n_checks++; if (data2 !== 64'hFFFF_FFFF_0000_ABCD) begin
      $display("FAIL short_bypass got %h exp ffffffff0000abcd", data2); n_fail++; end
  endtask

  task automatic test_back_pressure;
    do_write(5'd4, 64'h40, 1'b1);
    dout_retry = 1'b1;
    issue_read(5'd4, 5'd4);
    we = 1'b1; rd = 5'd4; dest = 64'h99; dest_long = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (data1 !== 64'h40 || rd_retry !== 1'b1 || dout_valid !== 1'b1) begin
        $display("FAIL hold_cycle%0d got d1=%h retry=%0b v=%0b exp 40/1/1", i, data1, rd_retry, dout_valid); n_fail++; end
      tick();
      we = 1'b0;
    end
    dout_retry = 1'b0;
    tick();
    n_checks++; if (dout_valid !== 1'b0) begin $display("FAIL release_clears got %0b exp 0", dout_valid); n_fail++; end
    issue_read(5'd4, 5'd4);
    n_checks++; if (data1 !== 64'h99) begin $display("FAIL after_pressure got %h exp 99", data1); n_fail++; end
  endtask

  task automatic test_back_to_back;
    logic [AW-1:0]   idx [3];
    logic [XLEN-1:0] exp [3];
    do_write(5'd5, 64'h5, 1'b1);
    idx[0] = 5'd3; exp[0] = 64'hAAAA_AAAA_1234_5678;
    idx[1] = 5'd7; exp[1] = 64'h22;
    idx[2] = 5'd5; exp[2] = 64'h5;
    rd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rs1 = idx[i]; rs2 = idx[2 - i];
      n_checks++; if (rd_retry !== 1'b0) begin $display("FAIL b2b_retry%0d got %0b exp 0", i, rd_retry); n_fail++; end
      tick();
      n_checks++; if (dout_valid !== 1'b1 || data1 !== exp[i] || data2 !== exp[2 - i]) begin
        $display("FAIL b2b_read%0d got v=%0b %h/%h exp 1 %h/%h", i, dout_valid, data1, data2, exp[i], exp[2 - i]); n_fail++; end
    end
    rd_valid = 1'b0;
    tick();
  endtask

  task automatic test_x0;
    do_write(5'd0, 64'hFF, 1'b1);
    ack_valid = 1'b1; ack_rd = 5'd0; ack_data = 64'hEE;
    tick();
    ack_valid = 1'b0;
    issue_read(5'd0, 5'd0);
`ifdef REGFILE_X0_ZERO_EN
    n_checks++; if (data1 !== 64'h0 || data2 !== 64'h0) begin
      $display("FAIL x0_zero got %h/%h exp 0/0", data1, data2); n_fail++; end
`else
    n_checks++; if (data1 !== 64'hEE || data2 !== 64'hEE) begin
      $display("FAIL x0_normal got %h/%h exp ee/ee", data1, data2); n_fail++; end
`endif
  endtask

  task automatic test_mid_sweep_reset;
    int n;
    do_write(5'd6, 64'h66, 1'b1);
    dout_retry = 1'b1;
    issue_read(5'd6, 5'd6);
    n_checks++; if (dout_valid !== 1'b1 || data1 !== 64'h66) begin
      $display("FAIL pending_out got v=%0b %h exp 1 66", dout_valid, data1); n_fail++; end
    pulse_reset();
    dout_retry = 1'b0;
    n_checks++; if (dout_valid !== 1'b0 || data1 !== 64'h0 || rd_retry !== 1'b1) begin
      $display("FAIL discard_pending got v=%0b d1=%h retry=%0b exp 0 0 1", dout_valid, data1, rd_retry); n_fail++; end
    repeat (10) tick();
    pulse_reset();
    wait_init(n);
    n_checks++; if (n != 32) begin $display("FAIL mid_sweep_len got %0d exp 32", n); n_fail++; end
    issue_read(5'd6, 5'd31);
    n_checks++; if (data1 !== 64'h0 || data2 !== 64'h0) begin
      $display("FAIL mid_sweep_cleared got %h/%h exp 0/0", data1, data2); n_fail++; end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_partial_write();
    test_collision_bypass();
    test_back_pressure();
    test_back_to_back();
    test_x0();
    test_mid_sweep_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL provide parameters, one per line: XLEN, 64, data width in bits; NREG, 32, entry count (power of two, >=4); AW, log2(NREG), register index width.
REQ-002 The block SHALL provide ports, one per line (name direction width meaning):
  clk  in  1  clock
  reset  in  1  reset, synchronous, active-high
  rd_valid  in  1  read request valid
  rd_retry  out  1  read request back-pressure
  rs1, rs2  in  AW  read indices
  we  in  1  execute write enable
  rd  in  AW  execute write index
  dest  in  XLEN  execute write data
  dest_long  in  1  1 = full-width write, 0 = lower 32 bits only
  ack_valid  in  1  data-cache writeback valid
  ack_rd  in  AW  writeback index
  ack_data  in  XLEN  writeback data (always full width)
  dout_valid  out  1  read result valid
  dout_retry  in  1  downstream back-pressure
  data1, data2  out  XLEN  read results
  init_done  out  1  clearing sweep complete

Function
REQ-003 The block SHALL have states CLEAR and READY; reset forces CLEAR with sweep counter 0.
REQ-004 In CLEAR, with reset low, the block SHALL zero entry[counter] and increment the counter each cycle, moving to READY in the cycle after entry NREG-1 is cleared (NREG cycles after reset deasserts).
REQ-005 While reset is high the counter SHALL stay 0 and no entry SHALL be written.
REQ-006 In CLEAR the block SHALL ignore we and ack_valid, hold rd_retry=1, and hold init_done=0.
REQ-007 In READY, with we=1, the block SHALL write dest to entry[rd] when dest_long=1, else dest[31:0] to entry[rd][31:0] with bits [XLEN-1:32] unchanged.
REQ-008 In READY, with ack_valid=1, the block SHALL write ack_data to entry[ack_rd] at full width.
REQ-009 When both writes target the same index in one cycle, the ack write SHALL take precedence for every bit.
REQ-010 Read acceptance SHALL occur when rd_valid=1 and rd_retry=0.
REQ-011 rd_retry SHALL equal (state!=READY) OR (dout_valid AND dout_retry).
REQ-012 On acceptance, data1/data2 SHALL be registered one cycle later from entry[rs1]/entry[rs2], with bypass from same-cycle writes: an ack hit returns ack_data; otherwise a we hit returns dest (dest_long=1) or {entry[XLEN-1:32], dest[31:0]} (dest_long=0).
REQ-013 dout_valid SHALL be set the cycle after acceptance, cleared the cycle after dout_valid=1 and dout_retry=0 with no new acceptance, and remain set across back-to-back acceptances.
REQ-014 While dout_valid=1 and dout_retry=1, data1/data2/dout_valid SHALL hold unchanged; later writes SHALL NOT modify held outputs.
REQ-015 Read latency SHALL be exactly 1 cycle; sustained throughput SHALL be one read per cycle when dout_retry=0.

Reset
REQ-016 Reset SHALL drive dout_valid=0, data1=0, data2=0, init_done=0, and rd_retry=1 on the next clock edge.
REQ-017 Reset asserted mid-sweep or mid-handshake SHALL restart the sweep from entry 0 and discard any pending output.
REQ-018 Entry contents SHALL NOT be cleared by reset directly; only the sweep (REQ-004) clears them.

Configuration
REQ-019 With macro REGFILE_X0_ZERO_EN defined, entry 0 SHALL read as zero on both ports, writes and bypass to index 0 SHALL be discarded, and the sweep SHALL still take NREG cycles.
REQ-020 Without REGFILE_X0_ZERO_EN, entry 0 SHALL behave as any other entry.

Verification
REQ-021 Sweep: entries preloaded nonzero; pulse reset 1 cycle -> init_done=0 for exactly 32 cycles, then 1; reads of rs1=5, rs2=31 -> 0, 0.
REQ-022 Partial write: write entry 3 = 0xAAAA_AAAA_5555_5555 long; write dest=0x1234_5678 with dest_long=0 -> read gives 0xAAAA_AAAA_1234_5678.
REQ-023 Collision and bypass: same cycle we rd=7 dest=0x11, ack_rd=7 ack_data=0x22, read rs1=rs2=7 -> data1=data2=0x22 next cycle; re-read later -> 0x22.
REQ-024 Back-pressure: dout_retry=1 for 3 cycles after a read of entry 4 (=0x40), write entry 4=0x99 meanwhile -> data1 stays 0x40, rd_retry=1; drop retry -> next read returns 0x99.
REQ-025 Mid-sweep reset: reset at sweep cycle 10 -> counter restarts at 0, init_done rises 32 cycles after the final reset deassert.
REQ-026 With REGFILE_X0_ZERO_EN: write entry 0=0xFF plus ack to 0 -> reads of rs1=0 return 0.
